// File: rtl/i2s_clk_rx.sv
// I2S slave clock receiver: synchronises external sclk/ws, strobes edges,
// tracks channel/bit position and reports lock, length errors and clock loss.
module i2s_clk_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic       pclk,
  input  logic       rst_,
  input  logic       en,
  input  logic       frame32,
  input  logic       sclk_in,
  input  logic       ws_in,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       frame_start,
  output logic       chan,
  output logic [5:0] bit_idx,
  output logic       locked,
  output logic       err_len,
  output logic       clk_lost
);

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    TRACK,
    LOCKED
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic                   r_sclk_hist;

  logic       r_rise, r_fall, r_fs, r_chan;
  logic       r_locked, r_err, r_lost;
  logic [5:0] r_bit;
  logic [3:0] r_good, w_good_nxt;
  logic [7:0] r_tmo;

  logic       w_sclk, w_ws, w_rise, w_fall, w_edge;
  logic       w_fs, w_len_ok, w_tmo_hit;
  logic       w_locked_nxt, w_err, w_lost;
  logic [6:0] w_len;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ws   = r_ws_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_hist;
  assign w_fall = ~w_sclk & r_sclk_hist;
  assign w_edge = w_rise | w_fall;
  assign w_fs   = en & w_rise & (w_ws != r_chan);

  assign w_len    = {1'b0, r_bit} + 7'd1;
  assign w_len_ok = w_len == (frame32 ? 7'd32 : 7'd16);

  // An edge this cycle clears the counter, so it can never fire with frame_start
  assign w_tmo_hit = ~w_edge &
                     (({1'b0, r_tmo} + 9'd1) == 9'(TIMEOUT));

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      r_sclk_sync <= '0;
      r_ws_sync   <= '0;
      r_sclk_hist <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], ws_in};
      r_sclk_hist <= w_sclk;
    end
  end

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_fs   <= 1'b0;
      r_chan <= 1'b0;
      r_bit  <= '0;
      r_tmo  <= '0;
    end else begin
      r_rise <= en & w_rise;
      r_fall <= en & w_fall;
      r_fs   <= w_fs;
      if (!en) begin
        r_bit <= '0;
      end else if (w_rise) begin
        r_chan <= w_ws;
        if (w_fs)
          r_bit <= '0;
        else if (r_bit != 6'd63)
          r_bit <= r_bit + 6'd1;
      end
      if (r_state == IDLE || w_edge)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + 8'd1;
    end
  end

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      r_state  <= IDLE;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      r_locked <= w_locked_nxt;
      r_err    <= w_err;
      r_lost   <= w_lost;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good;
    w_locked_nxt = r_locked;
    w_err        = 1'b0;
    w_lost       = 1'b0;
    if (!en) begin
      w_state_nxt  = IDLE;
      w_locked_nxt = 1'b0;
    end else if (r_state != IDLE && w_tmo_hit) begin
      w_state_nxt  = IDLE;
      w_locked_nxt = 1'b0;
      w_lost       = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: w_state_nxt = SEEK;
        SEEK: begin
          if (w_fs) begin
            w_state_nxt = TRACK;
            w_good_nxt  = '0;
          end
        end
        TRACK: begin
          if (w_fs && w_len_ok) begin
            w_good_nxt = r_good + 4'd1;
            if (r_good + 4'd1 == 4'(LOCK_FRAMES)) begin
              w_state_nxt  = LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else if (w_fs) begin
            w_err      = 1'b1;
            w_good_nxt = '0;
          end
        end
        LOCKED: begin
          if (w_fs && !w_len_ok) begin
            w_err        = 1'b1;
            w_locked_nxt = 1'b0;
            w_state_nxt  = TRACK;
            w_good_nxt   = '0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign sclk_rise   = r_rise;
  assign sclk_fall   = r_fall;
  assign frame_start = r_fs;
  assign chan        = r_chan;
  assign bit_idx     = r_bit;
  assign locked      = r_locked;
  assign err_len     = r_err;
  assign clk_lost    = r_lost;

endmodule

// File: tb/tb_i2s_clk_rx.sv
// Bench for i2s_clk_rx: scenario table, directed corner sequences and
// randomised half-frame streams checked against a per-bit reference model.
module tb_i2s_clk_rx;

  localparam int TMO = 64;
  localparam int P_SEEK = 1;
  localparam int P_TRACK = 2;
  localparam int P_LOCKED = 3;

  logic pclk = 0, rst_ = 0, en = 0, frame32 = 0, sclk_in = 0, ws_in = 0;
  logic sclk_rise, sclk_fall, frame_start, chan, locked, err_len, clk_lost;
  logic [5:0] bit_idx;

  i2s_clk_rx #(.SYNC_STAGES(2), .LOCK_FRAMES(2), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .rst_(rst_), .en(en), .frame32(frame32),
    .sclk_in(sclk_in), .ws_in(ws_in),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .frame_start(frame_start), .chan(chan), .bit_idx(bit_idx),
    .locked(locked), .err_len(err_len), .clk_lost(clk_lost)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int cyc;
    logic fs, err, lk, ch;
    logic [5:0] idx;
  } rise_t;

  typedef struct {
    bit f32;
    int len;
    int nh;
    int exp_err;
    bit exp_lk;
    int exp_lockfs;
  } row_t;

  rise_t rq[$];
  int fq[$];
  rise_t e;
  int cyc = 0, n_chk = 0, n_err = 0;
  int n_errlen = 0, d_fs = 0, d_lockfs = 0;
  int last_edge = 0, lost_cyc = -1;
  bit lost_ok = 0;
  bit cur_ws = 0;

  int m_phase, m_good, m_idx, m_nerr;
  bit m_chan, m_lk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge pclk) begin
    cyc++;
    #1;
    if (rst_) begin
      if (frame_start) d_fs++;
      if (locked && d_lockfs == 0) d_lockfs = d_fs;
      if (err_len) n_errlen++;
      if (sclk_rise) begin
        last_edge = cyc;
        if (rq.size() == 0) check("rise_spurious", sclk_rise, 0);
        else begin
          e = rq.pop_front();
          check("rise_lat", cyc, e.cyc);
          check("rise_out",
                {frame_start, err_len, locked, chan, bit_idx},
                {e.fs, e.err, e.lk, e.ch, e.idx});
        end
      end else begin
        if (frame_start | err_len)
          check("strobe_alone", {frame_start, err_len}, 0);
        if (rq.size() > 0 && rq[0].cyc < cyc) begin
          check("rise_missing", sclk_rise, 1);
          void'(rq.pop_front());
        end
      end
      if (sclk_fall) begin
        last_edge = cyc;
        if (fq.size() == 0) check("fall_spurious", sclk_fall, 0);
        else check("fall_lat", cyc, fq.pop_front());
      end else if (fq.size() > 0 && fq[0] < cyc) begin
        check("fall_missing", sclk_fall, 1);
        void'(fq.pop_front());
      end
      if (clk_lost) begin
        lost_cyc = cyc;
        check("lost_spurious", clk_lost, lost_ok);
      end
    end
  end

  task automatic model_reset();
    m_phase = P_SEEK;
    m_good = 0;
    m_idx = 0;
    m_nerr = 0;
    m_chan = 0;
    m_lk = 0;
    rq.delete();
    fq.delete();
    n_errlen = 0;
    d_fs = 0;
    d_lockfs = 0;
    cur_ws = 0;
  endtask

  // Reference: one call per sclk pin rise, expectations per I2S bit
  task automatic model_rise(bit w);
    bit fs, err, ok;
    rise_t r;
    fs = (w != m_chan);
    err = 0;
    if (fs) begin
      ok = (m_idx + 1) == (frame32 ? 32 : 16);
      if (m_phase == P_SEEK) begin
        m_phase = P_TRACK;
        m_good = 0;
      end else if (!ok) begin
        err = 1;
        m_nerr++;
        m_good = 0;
        m_phase = P_TRACK;
        m_lk = 0;
      end else if (m_phase == P_TRACK) begin
        m_good++;
        if (m_good == 2) begin
          m_phase = P_LOCKED;
          m_lk = 1;
        end
      end
      m_idx = 0;
    end else if (m_idx < 63) begin
      m_idx++;
    end
    m_chan = w;
    r.cyc = cyc + 3;
    r.fs = fs;
    r.err = err;
    r.lk = m_lk;
    r.ch = w;
    r.idx = 6'(m_idx);
    rq.push_back(r);
  endtask

  task automatic sbit(bit w);
    @(negedge pclk);
    if (sclk_in) fq.push_back(cyc + 3);
    sclk_in = 0;
    ws_in = w;
    repeat (3) @(negedge pclk);
    @(negedge pclk);
    sclk_in = 1;
    model_rise(w);
    repeat (3) @(negedge pclk);
  endtask

  task automatic half(int len);
    cur_ws = ~cur_ws;
    repeat (len) sbit(cur_ws);
  endtask

  task automatic do_reset(bit f32);
    @(negedge pclk);
    en = 0;
    rst_ = 0;
    sclk_in = 0;
    ws_in = 0;
    frame32 = f32;
    repeat (3) @(negedge pclk);
    rst_ = 1;
    model_reset();
    @(negedge pclk);
    en = 1;
  endtask

  row_t tbl[7];
  int lens[9];
  int rl;

  initial begin
    tbl[0] = '{0, 16, 2, 0, 1, 3};
    tbl[1] = '{1, 16, 3, 3, 0, 0};
    tbl[2] = '{1, 32, 2, 0, 1, 3};
    tbl[3] = '{0, 32, 2, 2, 0, 0};
    tbl[4] = '{0, 15, 3, 3, 0, 0};
    tbl[5] = '{0, 16, 1, 0, 0, 0};
    tbl[6] = '{0, 17, 2, 2, 0, 0};
    lens = '{16, 16, 16, 16, 15, 16, 16, 16, 16};

    repeat (2) @(negedge pclk);
    check("reset_state",
          {sclk_rise, sclk_fall, frame_start, chan, bit_idx,
           locked, err_len, clk_lost}, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset(tbl[i].f32);
      repeat (4) sbit(0);
      repeat (tbl[i].nh) half(tbl[i].len);
      half(1);
      check($sformatf("row%0d_err", i), n_errlen, tbl[i].exp_err);
      check($sformatf("row%0d_lock", i), locked, tbl[i].exp_lk);
      check($sformatf("row%0d_lockfs", i), d_lockfs, tbl[i].exp_lockfs);
    end

    // Short half-frame while locked, then relock
    do_reset(0);
    repeat (4) sbit(0);
    for (int i = 0; i < 9; i++) half(lens[i]);
    check("short_err", n_errlen, 1);
    check("short_relock", locked, 1);

    // ws held constant: bit_idx saturates, next toggle sees len 64
    half(100);
    check("idx_sat", bit_idx, 63);
    check("sat_no_err", n_errlen, 1);
    half(16);
    check("sat_err", n_errlen, 2);
    check("sat_unlock", locked, 0);

    // Clock stopped high after relock
    repeat (3) half(16);
    check("pre_lost_lock", locked, 1);
    lost_ok = 1;
    lost_cyc = -1;
    for (int i = 0; i < 200 && lost_cyc < 0; i++) begin
      @(posedge pclk);
      #2;
    end
    check("lost_delay", lost_cyc - last_edge, TMO);
    check("lost_unlock", locked, 0);
    lost_ok = 0;
    m_phase = P_SEEK;
    m_lk = 0;
    m_good = 0;
    repeat (4) half(16);
    check("lost_relock", locked, 1);

    // en dropped mid-frame
    repeat (5) sbit(cur_ws);
    @(negedge pclk);
    en = 0;
    @(posedge pclk);
    #1;
    check("en_off", {locked, bit_idx, chan, sclk_rise, frame_start},
          {1'b0, 6'd0, m_chan, 1'b0, 1'b0});
    repeat (5) @(negedge pclk);
    en = 1;
    m_phase = P_SEEK;
    m_lk = 0;
    m_good = 0;
    m_idx = 0;
    repeat (11) sbit(cur_ws);
    repeat (3) half(16);
    check("en_relock", locked, 1);

    // Async reset mid-frame while locked
    repeat (3) sbit(cur_ws);
    @(negedge pclk);
    #2;
    check("pre_rst_lock", locked, 1);
    rst_ = 0;
    sclk_in = 0;
    ws_in = 0;
    #1;
    check("async_rst",
          {sclk_rise, sclk_fall, frame_start, chan, bit_idx,
           locked, err_len, clk_lost}, 0);
    repeat (3) @(negedge pclk);
    rst_ = 1;
    model_reset();
    repeat (4) sbit(0);
    repeat (3) half(16);
    check("rst_relock", locked, 1);

    // Randomised half-frame lengths and frame32 changes
    do_reset(0);
    repeat (4) sbit(0);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) frame32 = ~frame32;
      case ($urandom_range(0, 7))
        0, 1, 2: rl = frame32 ? 32 : 16;
        3: rl = 15;
        4: rl = 17;
        5: rl = 31;
        6: rl = 33;
        default: rl = $urandom_range(1, 70);
      endcase
      half(rl);
    end
    check("rand_err_count", n_errlen, m_nerr);
    check("rand_lock", locked, m_lk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
